// File: rtl/bullet_pkg.sv
// Shared types and default constants for the tank-game bullet pool.
package bullet_pkg;

    localparam int COORD_W            = 10;
    localparam int NUM_SLOTS_DEF      = 4;
    localparam int MAX_PER_PLAYER_DEF = 2;
    localparam int COOLDOWN_TICKS_DEF = 16;
    localparam int BULLET_SPEED_DEF   = 2;
    localparam int SCREEN_W_DEF       = 640;
    localparam int SCREEN_H_DEF       = 480;
    localparam int TANK_CENTER_DEF    = 15;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef struct packed {
        logic               active;
        logic               owner;
        dir_t               dir;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: holds position and heading, moves on tick,
// and frees itself on a hit or on leaving the screen.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int BULLET_SPEED = BULLET_SPEED_DEF,
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic               hit_i,
    input  logic               alloc_i,
    input  logic               alloc_owner_i,
    input  logic [1:0]         alloc_dir_i,
    input  logic [COORD_W-1:0] alloc_x_i,
    input  logic [COORD_W-1:0] alloc_y_i,
    output logic               active_o,
    output logic               owner_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               free_o
);

    localparam logic [COORD_W:0] SPD = (COORD_W+1)'(BULLET_SPEED);
    localparam logic [COORD_W:0] SW  = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] SH  = (COORD_W+1)'(SCREEN_H);

    slot_t            slot_q;
    slot_t            slot_d;
    logic             exit_w;
    logic [COORD_W:0] x_ext;
    logic [COORD_W:0] y_ext;

    assign x_ext = {1'b0, slot_q.x};
    assign y_ext = {1'b0, slot_q.y};

    always_comb begin
        exit_w = 1'b0;
        unique case (slot_q.dir)
            DIR_UP:    exit_w = y_ext < SPD;
            DIR_DOWN:  exit_w = (y_ext + SPD) >= SH;
            DIR_LEFT:  exit_w = x_ext < SPD;
            DIR_RIGHT: exit_w = (x_ext + SPD) >= SW;
        endcase
    end

    // Allocation only targets inactive slots, so it never races a hit or a move.
    always_comb begin
        slot_d = slot_q;
        free_o = 1'b0;
        if (alloc_i) begin
            slot_d.active = 1'b1;
            slot_d.owner  = alloc_owner_i;
            slot_d.dir    = dir_t'(alloc_dir_i);
            slot_d.x      = alloc_x_i;
            slot_d.y      = alloc_y_i;
        end else if (slot_q.active && hit_i) begin
            slot_d.active = 1'b0;
            free_o        = 1'b1;
        end else if (slot_q.active && tick_i) begin
            if (exit_w) begin
                slot_d.active = 1'b0;
                free_o        = 1'b1;
            end else begin
                unique case (slot_q.dir)
                    DIR_UP:    slot_d.y = slot_q.y - SPD[COORD_W-1:0];
                    DIR_DOWN:  slot_d.y = slot_q.y + SPD[COORD_W-1:0];
                    DIR_LEFT:  slot_d.x = slot_q.x - SPD[COORD_W-1:0];
                    DIR_RIGHT: slot_d.x = slot_q.x + SPD[COORD_W-1:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign active_o = slot_q.active;
    assign owner_o  = slot_q.owner;
    assign x_o      = slot_q.x;
    assign y_o      = slot_q.y;

endmodule

// File: rtl/bullet_scheduler.sv
// Shared bullet pool for two players: edge capture, cooldown, per-player
// quota, round-robin grant into the lowest free slot.
module bullet_scheduler
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS      = NUM_SLOTS_DEF,
    parameter int MAX_PER_PLAYER = MAX_PER_PLAYER_DEF,
    parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_DEF,
    parameter int BULLET_SPEED   = BULLET_SPEED_DEF,
    parameter int SCREEN_W       = SCREEN_W_DEF,
    parameter int SCREEN_H       = SCREEN_H_DEF,
    parameter int TANK_CENTER    = TANK_CENTER_DEF
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         tick_i,
    input  logic                         player_1_shoot_i,
    input  logic                         player_2_shoot_i,
    input  logic [1:0]                   player_1_dir_i,
    input  logic [1:0]                   player_2_dir_i,
    input  logic [9:0]                   player_1_x_i,
    input  logic [9:0]                   player_1_y_i,
    input  logic [9:0]                   player_2_x_i,
    input  logic [9:0]                   player_2_y_i,
    input  logic                         hit_valid_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] hit_slot_i,
    output logic [NUM_SLOTS-1:0]         slot_active_o,
    output logic [NUM_SLOTS-1:0]         slot_owner_o,
    output logic [10*NUM_SLOTS-1:0]      slot_x_o,
    output logic [10*NUM_SLOTS-1:0]      slot_y_o,
    output logic [1:0]                   fire_grant_o,
    output logic                         pool_full_o
);

    localparam int IW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(MAX_PER_PLAYER + 1);
    localparam int DW = $clog2(COOLDOWN_TICKS + 1);

    logic [1:0]          shoot;
    logic [1:0]          rise;
    logic [1:0]          qual;
    logic [1:0]          elig;
    logic [1:0]          gnt;
    logic [1:0]          prev_q;
    logic [1:0]          pend_q;
    logic [1:0]          pend_d;
    logic [1:0]          grant_q;
    logic                rr_q;
    logic                rr_d;
    logic                full_q;
    logic [1:0][DW-1:0]  cd_q;
    logic [1:0][DW-1:0]  cd_d;
    logic [1:0][CW-1:0]  cnt_q;
    logic [1:0][CW-1:0]  cnt_d;
    logic [IW-1:0]       free_idx;
    logic                free_any;
    logic [NUM_SLOTS-1:0] alloc;
    logic [NUM_SLOTS-1:0] hit_vec;
    logic [NUM_SLOTS-1:0] free_vec;
    logic [NUM_SLOTS-1:0] act;
    logic [NUM_SLOTS-1:0] own;
    logic [1:0]          sp_dir;
    logic [9:0]          sp_x;
    logic [9:0]          sp_y;

    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!act[i]) begin
                free_idx = IW'(i);
                free_any = 1'b1;
            end
        end
    end

    // rr_q == 0 favours player 1; it points at the loser after each grant.
    always_comb begin
        shoot = {player_2_shoot_i, player_1_shoot_i};
        rise  = shoot & ~prev_q;
        for (int p = 0; p < 2; p++) begin
            qual[p] = rise[p] && (cd_q[p] == '0)
                   && (cnt_q[p] < CW'(MAX_PER_PLAYER));
        end
        elig = pend_q | qual;
        gnt  = 2'b00;
        if (free_any) begin
            if (elig == 2'b11) begin
                gnt = rr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = elig;
            end
        end
        pend_d = elig & ~gnt;
        rr_d   = (|gnt) ? gnt[0] : rr_q;
    end

    always_comb begin
        sp_dir = gnt[1] ? player_2_dir_i : player_1_dir_i;
        sp_x   = (gnt[1] ? player_2_x_i : player_1_x_i) + 10'(TANK_CENTER);
        sp_y   = (gnt[1] ? player_2_y_i : player_1_y_i) + 10'(TANK_CENTER);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            alloc[i]   = (|gnt) && (free_idx == IW'(i));
            hit_vec[i] = hit_valid_i && (hit_slot_i == IW'(i));
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            cnt_d[p] = cnt_q[p] + CW'(gnt[p]);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (free_vec[i] && (own[i] == p[0])) begin
                    cnt_d[p] = cnt_d[p] - CW'(1);
                end
            end
            if (gnt[p]) begin
                cd_d[p] = DW'(COOLDOWN_TICKS);
            end else if (tick_i && (cd_q[p] != '0)) begin
                cd_d[p] = cd_q[p] - DW'(1);
            end else begin
                cd_d[p] = cd_q[p];
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bullet_slot #(
            .BULLET_SPEED (BULLET_SPEED),
            .SCREEN_W     (SCREEN_W),
            .SCREEN_H     (SCREEN_H)
        ) u_slot (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .tick_i        (tick_i),
            .hit_i         (hit_vec[i]),
            .alloc_i       (alloc[i]),
            .alloc_owner_i (gnt[1]),
            .alloc_dir_i   (sp_dir),
            .alloc_x_i     (sp_x),
            .alloc_y_i     (sp_y),
            .active_o      (act[i]),
            .owner_o       (own[i]),
            .x_o           (slot_x_o[i*10 +: 10]),
            .y_o           (slot_y_o[i*10 +: 10]),
            .free_o        (free_vec[i])
        );
    end

    // Full flag tracks the next active vector so it lines up with slot_active_o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q  <= 2'b11;
            pend_q  <= '0;
            rr_q    <= 1'b0;
            grant_q <= '0;
            full_q  <= 1'b0;
            cd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= shoot;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            grant_q <= gnt;
            full_q  <= &((act | alloc) & ~free_vec);
            cd_q    <= cd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign slot_active_o = act;
    assign slot_owner_o  = own;
    assign fire_grant_o  = grant_q;
    assign pool_full_o   = full_q;

endmodule
